count_sweep_ctrl: RTL and testbench

COUNT_SWEEP_CTRL -- requirements
Module: count_sweep_ctrl

---
 rtl/count_sweep_pkg.sv | 22 ++
 rtl/updown_load_cnt.sv | 36 +++
 rtl/count_sweep_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_count_sweep_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/count_sweep_pkg.sv
// rtl/count_sweep_pkg.sv - shared FSM state and mode codes for the sweep controller
// Contents: state_t (IDLE, PRIME, RUN, DONE), mode codes MODE_UP/MODE_DN/MODE_TRI,
// and is_tri() which treats both 10 and 11 as triangle.
package count_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_UP  = 2'b00;
  localparam logic [1:0] MODE_DN  = 2'b01;
  localparam logic [1:0] MODE_TRI = 2'b10;

  // Any code with the triangle bit set (10 or 11) sweeps as a triangle.
  function automatic logic is_tri(input logic [1:0] m);
    return (m & MODE_TRI) != 2'b00;
  endfunction

endpackage

// File: rtl/updown_load_cnt.sv
// rtl/updown_load_cnt.sv - WIDTH-bit up/down counter with synchronous load and enable
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset, clears the count
//   i_load   in   load i_value (has priority over i_en)
//   i_value  in   WIDTH  load value
//   i_en     in   step the counter by one
//   i_up     in   1 = increment, 0 = decrement
//   o_count  out  WIDTH  current count
module updown_load_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_en,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_en) begin
      r_count <= i_up ? r_count + 1'b1 : r_count - 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/count_sweep_ctrl.sv
// rtl/count_sweep_ctrl.sv - bounded sawtooth/triangle sweep controller with repeat count
// Optional feature: define COUNT_SWEEP_PAUSE_EN to add the pause input (freezes RUN).
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-low reset
//   start  in   begin a sweep program (sampled in IDLE only)
//   stop   in   abort; returns to IDLE holding count/dir
//   mode   in   2      00 up-saw, 01 down-saw, 1x triangle
//   lo/hi  in   WIDTH  inclusive sweep bounds
//   reps   in   REP_W  number of sweeps, 0 = run until stop
//   pause  in   (COUNT_SWEEP_PAUSE_EN only) freeze RUN
//   count  out  WIDTH  current counter value
//   dir    out  1 = counting up
//   busy   out  high in PRIME and RUN
//   wrap   out  one-cycle pulse at each sweep end
//   done   out  one-cycle pulse on program completion
//   err    out  one-cycle pulse on a start with lo > hi
module count_sweep_ctrl
  import count_sweep_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [REP_W-1:0] reps,
`ifdef COUNT_SWEEP_PAUSE_EN
  input  logic             pause,
`endif
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             busy,
  output logic             wrap,
  output logic             done,
  output logic             err
);

  state_t           r_state;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [1:0]       r_mode;
  logic [REP_W-1:0] r_reps;
  logic [REP_W-1:0] r_sweeps;
  logic             r_dir;
  logic             r_busy;
  logic             r_wrap;
  logic             r_done;
  logic             r_err;

  logic [WIDTH-1:0] w_count;
  logic             w_pause;
  logic             w_load;
  logic [WIDTH-1:0] w_value;
  logic             w_en;
  logic             w_up;
  logic             w_wrap_ev;
  logic             w_final;
  logic             w_dir_nxt;
  logic             w_at_lo;
  logic             w_at_hi;

`ifdef COUNT_SWEEP_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_at_lo = (w_count == r_lo);
  assign w_at_hi = (w_count == r_hi);
  // The sweep ending now is the last one when it brings the tally up to reps.
  assign w_final = (r_reps != '0) && ((r_sweeps + 1'b1) == r_reps);

  // Counter steering. Bounds are checked before every step so the counter
  // never leaves [lo,hi] and never relies on modular wrap at 0 or all-ones.
  always_comb begin
    w_load    = 1'b0;
    w_value   = r_lo;
    w_en      = 1'b0;
    w_up      = 1'b1;
    w_wrap_ev = 1'b0;
    w_dir_nxt = r_dir;
    case (r_state)
      PRIME: begin
        if (!stop) begin
          w_load  = 1'b1;
          w_value = (r_mode == MODE_DN) ? r_hi : r_lo;
        end
      end
      RUN: begin
        if (!stop && !w_pause) begin
          if (is_tri(r_mode)) begin
            if (r_lo == r_hi) begin
              // Degenerate triangle: nowhere to go, every cycle is a sweep end.
              w_wrap_ev = 1'b1;
            end else if (r_dir) begin
              w_en = 1'b1;
              if (w_at_hi) begin
                w_up      = 1'b0;
                w_dir_nxt = 1'b0;
              end
            end else begin
              w_en = 1'b1;
              if (w_at_lo) begin
                w_wrap_ev = 1'b1;
                w_dir_nxt = 1'b1;
              end else begin
                w_up = 1'b0;
              end
            end
          end else if (r_mode == MODE_DN) begin
            if (w_at_lo) begin
              w_wrap_ev = 1'b1;
              w_load    = 1'b1;
              w_value   = r_hi;
            end else begin
              w_en = 1'b1;
              w_up = 1'b0;
            end
          end else begin
            if (w_at_hi) begin
              w_wrap_ev = 1'b1;
              w_load    = 1'b1;
              w_value   = r_lo;
            end else begin
              w_en = 1'b1;
            end
          end
          // The last sweep end freezes count and dir where they are.
          if (w_wrap_ev && w_final) begin
            w_load    = 1'b0;
            w_en      = 1'b0;
            w_dir_nxt = r_dir;
          end
        end
      end
      default: ;
    endcase
  end

  updown_load_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_value (w_value),
    .i_en    (w_en),
    .i_up    (w_up),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_lo     <= '0;
      r_hi     <= '0;
      r_mode   <= MODE_UP;
      r_reps   <= '0;
      r_sweeps <= '0;
      r_dir    <= 1'b0;
      r_busy   <= 1'b0;
      r_wrap   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          // stop outranks start; a bad range is flagged without capturing.
          if (start && !stop) begin
            if (lo <= hi) begin
              r_lo     <= lo;
              r_hi     <= hi;
              r_mode   <= mode;
              r_reps   <= reps;
              r_sweeps <= '0;
              r_busy   <= 1'b1;
              r_state  <= PRIME;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        PRIME: begin
          if (stop) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_dir   <= (r_mode != MODE_DN);
            r_state <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (!w_pause) begin
            r_dir <= w_dir_nxt;
            if (w_wrap_ev) begin
              r_wrap   <= 1'b1;
              r_sweeps <= r_sweeps + 1'b1;
              if (w_final) begin
                r_busy  <= 1'b0;
                r_state <= DONE;
              end
            end
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign count = w_count;
  assign dir   = r_dir;
  assign busy  = r_busy;
  assign wrap  = r_wrap;
  assign done  = r_done;
  assign err   = r_err;

endmodule

// File: tb/tb_count_sweep_ctrl.sv
// tb/tb_count_sweep_ctrl.sv - self-checking bench for count_sweep_ctrl
module tb_count_sweep_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       pause;
  logic [1:0] mode;
  logic [7:0] lo;
  logic [7:0] hi;
  logic [7:0] reps;
  logic [7:0] count;
  logic       dir;
  logic       busy;
  logic       wrap;
  logic       done;
  logic       err;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       rst;
    logic       start;
    logic       stop;
    logic       pause;
    logic [1:0] mode;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [7:0] reps;
    logic [7:0] ecount;
    logic       edir;
    logic       ebusy;
    logic       ewrap;
    logic       edone;
    logic       eerr;
  } rec_t;

  typedef struct {
    int         tag;
    logic [7:0] count;
    logic       dir;
    logic       busy;
    logic       wrap;
    logic       done;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t ce;
  rec_t tbl[$];

  count_sweep_ctrl #(
    .WIDTH (8),
    .REP_W (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .lo    (lo),
    .hi    (hi),
    .reps  (reps),
`ifdef COUNT_SWEEP_PAUSE_EN
    .pause (pause),
`endif
    .count (count),
    .dir   (dir),
    .busy  (busy),
    .wrap  (wrap),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d expected %0d", nm, tag, act, exp);
    end
  endtask

  function automatic rec_t mk(logic rs, logic st, logic sp, logic [1:0] md, logic [7:0] l,
                              logic [7:0] h, logic [7:0] rp, logic [7:0] c, logic d,
                              logic b, logic w, logic dn, logic e);
    rec_t r;
    r.rst = rs; r.start = st; r.stop = sp; r.pause = 1'b0; r.mode = md;
    r.lo = l; r.hi = h; r.reps = rp;
    r.ecount = c; r.edir = d; r.ebusy = b; r.ewrap = w; r.edone = dn; r.eerr = e;
    return r;
  endfunction

  // Drive one cycle of inputs, queue what must appear after the next rising edge.
  int step_no = 0;
  task automatic step(input rec_t r);
    exp_t e;
    reset = r.rst; start = r.start; stop = r.stop; pause = r.pause;
    mode = r.mode; lo = r.lo; hi = r.hi; reps = r.reps;
    e.tag = step_no; e.count = r.ecount; e.dir = r.edir; e.busy = r.ebusy;
    e.wrap = r.ewrap; e.done = r.edone; e.err = r.eerr;
    sb.push_back(e);
    step_no++;
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      ce = sb.pop_front();
      chk("count", ce.tag, 32'(count), 32'(ce.count));
      chk("dir",   ce.tag, 32'(dir),   32'(ce.dir));
      chk("busy",  ce.tag, 32'(busy),  32'(ce.busy));
      chk("wrap",  ce.tag, 32'(wrap),  32'(ce.wrap));
      chk("done",  ce.tag, 32'(done),  32'(ce.done));
      chk("err",   ce.tag, 32'(err),   32'(ce.err));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rec_t r;
    int   k;
    //            rst st sp md lo   hi   rp  | cnt dir busy wrap done err
    // up-saw 3..6, two sweeps; inputs scrambled after capture
    tbl.push_back(mk(1, 1, 0, 0, 3,   6,   2,    0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0,   1,   1,    3, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0,   1,   1,    4, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0,   1,   1,    5, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0,   1,   1,    6, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0,   1,   1,    3, 1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0,   1,   1,    4, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0,   1,   1,    5, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0,   1,   1,    6, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0,   1,   1,    6, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0,   1,   1,    6, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0,   1,   1,    6, 1, 0, 0, 0, 0));
    // lo > hi rejected
    tbl.push_back(mk(1, 1, 0, 0, 9,   4,   1,    6, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 9,   4,   1,    6, 1, 0, 0, 0, 0));
    // start with stop in IDLE: stop wins
    tbl.push_back(mk(1, 1, 1, 0, 1,   2,   1,    6, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1,   2,   1,    6, 1, 0, 0, 0, 0));
    // reset, then lo==hi==7 down-saw three sweeps
    tbl.push_back(mk(0, 0, 0, 0, 0,   0,   0,    0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 7,   7,   3,    0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2, 0, 200,   0,    7, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2, 0, 200,   0,    7, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2, 0, 200,   0,    7, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2, 0, 200,   0,    7, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2, 0, 200,   0,    7, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 2, 0, 200,   0,    7, 0, 0, 0, 0, 0));
    // down-saw 1..3, one sweep
    tbl.push_back(mk(1, 1, 0, 1, 1,   3,   1,    7, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,   0,   0,    3, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,   0,   0,    2, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,   0,   0,    1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,   0,   0,    1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,   0,   0,    1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,   0,   0,    1, 0, 0, 0, 0, 0));
    // stop during PRIME
    tbl.push_back(mk(1, 1, 0, 0, 10, 12,   0,    1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 10, 12,   0,    1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 10, 12,   0,    1, 0, 0, 0, 0, 0));
    // endless up-saw 0..9, stop at count 5
    tbl.push_back(mk(1, 1, 0, 0, 0,   9,   0,    1, 0, 1, 0, 0, 0));
    for (int i = 0; i <= 5; i++)
      tbl.push_back(mk(1, 0, 0, 0, 0, 9, 0, 8'(i), 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0,   9,   0,    5, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,   9,   0,    5, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,   9,   0,    5, 1, 0, 0, 0, 0));
    // restart, then reset during RUN
    tbl.push_back(mk(1, 1, 0, 0, 0,   9,   0,    5, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,   9,   0,    0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,   9,   0,    1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,   9,   0,    0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,   9,   0,    0, 0, 0, 0, 0, 0));

    reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    mode = 2'b00; lo = 8'd0; hi = 8'd0; reps = 8'd0;
    @(negedge clk);
    #1;
    chk("rst_count", -1, 32'(count), 0);
    chk("rst_busy",  -1, 32'(busy),  0);
    chk("rst_dir",   -1, 32'(dir),   0);
    chk("rst_pulse", -1, 32'({wrap, done, err}), 0);

    // reset is released in the first row together with start
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // full-range triangle, one sweep; a start and new bounds mid-run are ignored
    step(mk(1, 1, 0, 2, 0, 255, 1, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i <= 255; i++) begin
      if (i == 5) r = mk(1, 1, 0, 0, 50, 60, 9, 8'(i), 1, 1, 0, 0, 0);
      else        r = mk(1, 0, 0, 3, 0, 255, 1, 8'(i), 1, 1, 0, 0, 0);
      step(r);
    end
    for (int i = 254; i >= 0; i--)
      step(mk(1, 0, 0, 3, 0, 255, 1, 8'(i), 0, 1, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // reset mid-RUN must clear outputs without waiting for a clock edge
    step(mk(1, 1, 0, 0, 0, 9, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i <= 3; i++)
      step(mk(1, 0, 0, 0, 0, 9, 0, 8'(i), 1, 1, 0, 0, 0));
    reset = 1'b0;
    #1;
    chk("arst_count", -2, 32'(count), 0);
    chk("arst_dir",   -2, 32'(dir),   0);
    chk("arst_busy",  -2, 32'(busy),  0);
    chk("arst_pulse", -2, 32'({wrap, done, err}), 0);

    // pause for four cycles at count 4 (without the feature the count runs on)
    step(mk(1, 1, 0, 0, 0, 9, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i <= 4; i++)
      step(mk(1, 0, 0, 0, 0, 9, 0, 8'(i), 1, 1, 0, 0, 0));
    for (int i = 1; i <= 5; i++) begin
`ifdef COUNT_SWEEP_PAUSE_EN
      k = (i == 5) ? 5 : 4;
`else
      k = 4 + i;
`endif
      r = mk(1, 0, 0, 0, 0, 9, 0, 8'(k), 1, 1, 0, 0, 0);
      r.pause = (i != 5);
      step(r);
    end
    step(mk(1, 0, 1, 0, 0, 9, 0, 8'(k), 1, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 9, 0, 8'(k), 1, 0, 0, 0, 0));

    chk("sb_drained", -3, 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
